// File: rtl/vx_mem_tag_remap_pkg.sv
// Shared sizing helpers for the memory tag remapper and for clusters that
// need to size their downstream tag to match it.
package vx_mem_tag_remap_pkg;

    localparam int DEFAULT_NUM_IDS = 8;

    // Width of an outstanding-read ID; never narrower than one bit.
    function automatic int id_width(input int num_ids);
        return (num_ids > 1) ? $clog2(num_ids) : 1;
    endfunction

    // Width of the tag seen by the next memory level after remapping.
    function automatic int remap_tag_width(input int num_ids);
        return id_width(num_ids);
    endfunction

endpackage

// File: rtl/vx_mem_tag_remap_free_list.sv
// Free list of outstanding-read IDs: lowest-index allocation, release by ID,
// and a running count of IDs in use. Usable by any MSHR-like block.
module vx_mem_tag_remap_free_list
    import vx_mem_tag_remap_pkg::*;
#(
    parameter int NUM_IDS  = DEFAULT_NUM_IDS,
    parameter int ID_WIDTH = id_width(NUM_IDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_en,
    output logic [ID_WIDTH-1:0] alloc_id,
    output logic                any_free,
    input  logic                release_en,
    input  logic [ID_WIDTH-1:0] release_id,
    output logic                release_err,
    output logic [ID_WIDTH:0]   count
);

    localparam int CNT_W = ID_WIDTH + 1;

    logic [NUM_IDS-1:0] free_mask_q, free_mask_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               release_ok;

    // Priority encoder over the registered mask; a just-freed ID only
    // becomes allocatable once it lands in free_mask_q.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (free_mask_q[i]) begin
                alloc_id = ID_WIDTH'(i);
            end
        end
        any_free = |free_mask_q;
    end

    // Next mask and count; releasing an ID that is already free is an error
    // and leaves the state untouched.
    always_comb begin
        release_err = release_en & free_mask_q[release_id];
        release_ok  = release_en & ~free_mask_q[release_id];
        free_mask_d = free_mask_q;
        count_d     = count_q;
        if (alloc_en) begin
            free_mask_d[alloc_id] = 1'b0;
        end
        if (release_ok) begin
            free_mask_d[release_id] = 1'b1;
        end
        case ({alloc_en, release_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset returns every ID to the free pool.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_mask_q <= '1;
            count_q     <= '0;
        end else begin
            free_mask_q <= free_mask_d;
            count_q     <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vx_mem_tag_remap.sv
// Compresses the wide upstream memory tag into a small outstanding-read ID,
// keeps the original tag in an ID-indexed table and restores it on the
// response. Writes pass straight through and never consume an ID.
module vx_mem_tag_remap
    import vx_mem_tag_remap_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 12,
    parameter int NUM_IDS      = DEFAULT_NUM_IDS,
    parameter int ID_WIDTH     = id_width(NUM_IDS)
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_req_valid,
    output logic                    in_req_ready,
    input  logic                    in_req_rw,
    input  logic [ADDR_WIDTH-1:0]   in_req_addr,
    input  logic [DATA_SIZE-1:0]    in_req_byteen,
    input  logic [8*DATA_SIZE-1:0]  in_req_data,
    input  logic [TAG_IN_WIDTH-1:0] in_req_tag,

    output logic                    out_req_valid,
    input  logic                    out_req_ready,
    output logic                    out_req_rw,
    output logic [ADDR_WIDTH-1:0]   out_req_addr,
    output logic [DATA_SIZE-1:0]    out_req_byteen,
    output logic [8*DATA_SIZE-1:0]  out_req_data,
    output logic [ID_WIDTH-1:0]     out_req_tag,

    input  logic                    out_rsp_valid,
    output logic                    out_rsp_ready,
    input  logic [8*DATA_SIZE-1:0]  out_rsp_data,
    input  logic [ID_WIDTH-1:0]     out_rsp_tag,

    output logic                    in_rsp_valid,
    input  logic                    in_rsp_ready,
    output logic [8*DATA_SIZE-1:0]  in_rsp_data,
    output logic [TAG_IN_WIDTH-1:0] in_rsp_tag,

    output logic [ID_WIDTH:0]       pending_count,
    output logic                    tag_error
);

    logic                    any_free;
    logic [ID_WIDTH-1:0]     alloc_id;
    logic                    req_allow;
    logic                    read_fire;
    logic                    rsp_fire;
    logic                    release_err;
    logic                    tag_error_q, tag_error_d;
    logic [TAG_IN_WIDTH-1:0] tag_table_q [NUM_IDS];
    logic [TAG_IN_WIDTH-1:0] tag_table_d [NUM_IDS];

    // Request and response handshakes; all four are held off during reset
    // and none of the valids look at a ready.
    always_comb begin
        req_allow      = in_req_rw | any_free;
        out_req_valid  = in_req_valid & req_allow & ~reset;
        in_req_ready   = out_req_ready & req_allow & ~reset;
        read_fire      = in_req_valid & in_req_ready & ~in_req_rw;
        out_req_rw     = in_req_rw;
        out_req_addr   = in_req_addr;
        out_req_byteen = in_req_byteen;
        out_req_data   = in_req_data;
        out_req_tag    = in_req_rw ? '0 : alloc_id;

        in_rsp_valid   = out_rsp_valid & ~reset;
        out_rsp_ready  = in_rsp_ready & ~reset;
        rsp_fire       = out_rsp_valid & out_rsp_ready;
        in_rsp_data    = out_rsp_data;
        in_rsp_tag     = tag_table_q[out_rsp_tag];
    end

    vx_mem_tag_remap_free_list #(
        .NUM_IDS  (NUM_IDS),
        .ID_WIDTH (ID_WIDTH)
    ) free_list (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (read_fire),
        .alloc_id    (alloc_id),
        .any_free    (any_free),
        .release_en  (rsp_fire),
        .release_id  (out_rsp_tag),
        .release_err (release_err),
        .count       (pending_count)
    );

    // Capture the original tag in the slot of the ID handed out this cycle.
    always_comb begin
        tag_table_d = tag_table_q;
        if (read_fire) begin
            tag_table_d[alloc_id] = in_req_tag;
        end
    end

    // Tag table holds payload only, so it carries no reset.
    always_ff @(posedge clk) begin
        tag_table_q <= tag_table_d;
    end

    // Sticky error for a response that names an ID not currently in flight.
    always_comb begin
        tag_error_d = tag_error_q | release_err;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_error_q <= 1'b0;
        end else begin
            tag_error_q <= tag_error_d;
        end
    end

    assign tag_error = tag_error_q;

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
// Self-checking bench for vx_mem_tag_remap: directed scenarios followed by
// randomized traffic, all compared against a behavioural ID-pool model.
module tb_vx_mem_tag_remap;

    localparam int DS  = 64;
    localparam int AW  = 26;
    localparam int TW  = 12;
    localparam int NI  = 8;
    localparam int IW  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_req_valid, in_req_ready, in_req_rw;
    logic [AW-1:0]  in_req_addr;
    logic [DS-1:0]  in_req_byteen;
    logic [8*DS-1:0] in_req_data;
    logic [TW-1:0]  in_req_tag;
    logic           out_req_valid, out_req_ready, out_req_rw;
    logic [AW-1:0]  out_req_addr;
    logic [DS-1:0]  out_req_byteen;
    logic [8*DS-1:0] out_req_data;
    logic [IW-1:0]  out_req_tag;
    logic           out_rsp_valid, out_rsp_ready;
    logic [8*DS-1:0] out_rsp_data;
    logic [IW-1:0]  out_rsp_tag;
    logic           in_rsp_valid, in_rsp_ready;
    logic [8*DS-1:0] in_rsp_data;
    logic [TW-1:0]  in_rsp_tag;
    logic [IW:0]    pending_count;
    logic           tag_error;

    vx_mem_tag_remap #(
        .DATA_SIZE(DS), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .NUM_IDS(NI)
    ) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
        .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_byteen(in_req_byteen), .in_req_data(in_req_data),
        .in_req_tag(in_req_tag),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
        .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_byteen(out_req_byteen), .out_req_data(out_req_data),
        .out_req_tag(out_req_tag),
        .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready),
        .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready),
        .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .pending_count(pending_count), .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which IDs are in flight, what tag each carries.
    bit          busy [NI];
    logic [TW-1:0] tagmem [NI];
    int          pend;
    bit          err;
    int          obs_id;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NI; i++) if (!busy[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) busy[i] = 1'b0;
        pend = 0;
        err  = 1'b0;
    endtask

    // One clock of traffic: drive, check combinational outputs, clock,
    // update the model, check registered state.
    task automatic step(input bit rv, input bit rw, input logic [TW-1:0] tag,
                        input bit oready, input bit rspv, input logic [IW-1:0] rtag,
                        input bit iready);
        bit allow, rf, pf;
        int lf;
        in_req_valid  = rv;
        in_req_rw     = rw;
        in_req_tag    = tag;
        in_req_addr   = AW'($urandom);
        in_req_byteen = {$urandom, $urandom};
        in_req_data   = {16{$urandom}};
        out_req_ready = oready;
        out_rsp_valid = rspv;
        out_rsp_tag   = rtag;
        out_rsp_data  = {16{$urandom}};
        in_rsp_ready  = iready;
        #2;
        allow = rw || (pend < NI);
        lf    = lowest_free();
        obs_id = int'(out_req_tag);
        check("out_req_valid", 64'(out_req_valid), 64'(rv && allow));
        check("in_req_ready", 64'(in_req_ready), 64'(oready && allow));
        if (rv) begin
            check("out_req_rw", 64'(out_req_rw), 64'(rw));
            check("out_req_addr", 64'(out_req_addr), 64'(in_req_addr));
            check("out_req_byteen", out_req_byteen[63:0], in_req_byteen[63:0]);
            check("out_req_data", out_req_data[63:0], in_req_data[63:0]);
            if (allow) check("out_req_tag", 64'(out_req_tag), rw ? 64'd0 : 64'(lf));
        end
        check("in_rsp_valid", 64'(in_rsp_valid), 64'(rspv));
        check("out_rsp_ready", 64'(out_rsp_ready), 64'(iready));
        if (rspv) check("in_rsp_data", in_rsp_data[63:0], out_rsp_data[63:0]);
        if (rspv && busy[rtag]) check("in_rsp_tag", 64'(in_rsp_tag), 64'(tagmem[rtag]));
        rf = rv && oready && allow && !rw;
        pf = rspv && iready;
        @(posedge clk);
        if (pf) begin
            if (busy[rtag]) begin
                busy[rtag] = 1'b0;
                pend--;
            end else begin
                err = 1'b1;
            end
        end
        if (rf) begin
            busy[lf]   = 1'b1;
            tagmem[lf] = tag;
            pend++;
        end
        #1;
        check("pending_count", 64'(pending_count), 64'(pend));
        check("tag_error", 64'(tag_error), 64'(err));
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        in_req_valid  = 1'b1;
        in_req_rw     = 1'b0;
        out_req_ready = 1'b1;
        out_rsp_valid = 1'b1;
        in_rsp_ready  = 1'b1;
        #2;
        check("rst_in_req_ready", 64'(in_req_ready), 64'd0);
        check("rst_out_req_valid", 64'(out_req_valid), 64'd0);
        check("rst_in_rsp_valid", 64'(in_rsp_valid), 64'd0);
        check("rst_out_rsp_ready", 64'(out_rsp_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check("rst_pending", 64'(pending_count), 64'd0);
        check("rst_tag_error", 64'(tag_error), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_req_valid = 0; in_req_rw = 0; in_req_addr = '0; in_req_byteen = '0;
        in_req_data = '0; in_req_tag = '0; out_req_ready = 0; out_rsp_valid = 0;
        out_rsp_data = '0; out_rsp_tag = '0; in_rsp_ready = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Fill all eight IDs with tags 0x100..0x107.
        for (int i = 0; i < NI; i++) begin
            step(1, 0, TW'(12'h100 + i), 1, 0, 0, 1);
            check("fill_id", 64'(obs_id), 64'(i));
        end
        check("full_pending", 64'(pending_count), 64'd8);
        // Ninth read must stall; a write still flows.
        step(1, 0, 12'h108, 1, 0, 0, 1);
        check("full_stall", 64'(pending_count), 64'd8);
        step(1, 1, 12'h0, 1, 0, 0, 1);
        check("full_write_pending", 64'(pending_count), 64'd8);

        // Out-of-order returns, then lowest free wins.
        step(0, 0, 0, 1, 1, 3'd5, 1);
        step(0, 0, 0, 1, 1, 3'd2, 1);
        step(0, 0, 0, 1, 1, 3'd7, 1);
        step(1, 0, 12'h200, 1, 0, 0, 1);
        check("next_lowest", 64'(obs_id), 64'd2);

        // Only ID 0 free; read and release of ID 3 in the same cycle.
        step(1, 0, 12'h201, 1, 0, 0, 1);
        step(1, 0, 12'h202, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1, 3'd0, 1);
        step(1, 0, 12'h203, 1, 1, 3'd3, 1);
        check("simul_id", 64'(obs_id), 64'd0);
        check("simul_pending", 64'(pending_count), 64'd7);

        // Double release of ID 4 raises a sticky error.
        step(0, 0, 0, 1, 1, 3'd4, 1);
        step(0, 0, 0, 1, 1, 3'd4, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        check("err_sticky", 64'(tag_error), 64'd1);
        check("err_pending", 64'(pending_count), 64'd6);

        // Reset with five reads outstanding.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, TW'(12'h300 + i), 1, 0, 0, 1);
        do_reset();
        step(1, 0, 12'h400, 1, 0, 0, 1);
        check("post_reset_id", 64'(obs_id), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            logic [IW-1:0] rt;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                rt = IW'($urandom);
                if (pend > 0 && $urandom_range(0, 19) != 0) begin
                    for (int k = 0; k < 16; k++) begin
                        rt = IW'($urandom);
                        if (busy[rt]) break;
                    end
                end
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, TW'($urandom),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rt,
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
